// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: state encoding,
// default sizes and the occupancy mapping.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // The encoding is chosen so the state value is the entry count.
  function automatic logic [1:0] state_occ(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_dreg.sv
// WIDTH-bit data register with load enable and async active-high clear,
// clocked on the falling edge like the rest of the pipeline registers.
module pipe_dreg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage between pipeline boundaries: main register feeds
// out_data, skid register absorbs one extra beat when downstream stalls.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | nothing held; out_valid low
//   ST_ONE   | head in main; can accept and release together
//   ST_TWO   | head in main, next in skid; in_ready low
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  pipe_state_t      state;
  pipe_state_t      state_nxt;
  logic             accept;
  logic             release_h;
  logic             main_en;
  logic             main_from_skid;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  assign in_ready  = (state != ST_TWO) & ~flush;
  assign out_valid = (state != ST_EMPTY) & ~flush;
  assign accept    = in_valid & in_ready;
  assign release_h = out_valid & out_ready;
  assign occupancy = state_occ(state);
  assign out_data  = main_q;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush wins outright; accept/release are already masked by flush above,
  // so no register write can happen in a flush cycle.
  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_en   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !release_h) begin
            skid_en   = 1'b1;
            state_nxt = ST_TWO;
          end else if (accept && release_h) begin
            main_en   = 1'b1;
          end else if (release_h) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (release_h) begin
            main_en        = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_dreg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .clr (clr),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_dreg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .clr (clr),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  // One extra sum bit catches overflow so the count pins at all-ones.
  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(occupancy);
  assign drop_nxt = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: stimulus pushes expected payloads into
// a queue, a monitor pops and compares on every release.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [7:0]  drop_cnt;

  logic        s_flush = 1'b0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_in_data = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [7:0]  s_out_data;
  logic [1:0]  s_occupancy;
  logic [1:0]  s_drop_cnt;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );

  pipe_skid_stage #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .clr(clr), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .drop_cnt(s_drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the active (falling) edge.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    cyc();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    cyc(n);
  endtask

  task automatic fill2(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0;
    send(a);
    send(b);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    cyc();
    flush = 1'b0;
    #0;
  endtask

  task automatic sat_round(input logic [1:0] exp_cnt);
    s_in_valid = 1'b1;
    s_in_data  = 8'h3C;
    cyc(2);
    s_in_valid = 1'b0;
    s_flush    = 1'b1;
    cyc();
    s_flush    = 1'b0;
    #0;
    chk("sat_drop_cnt", {30'd0, s_drop_cnt}, {30'd0, exp_cnt});
  endtask

  // Monitor samples mid-cycle (rising edge), ahead of the active falling edge.
  always @(posedge clk) begin
    if (!clr && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got=%h want=none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          bad++;
          $display("FAIL sb_data: got=%h want=%h", out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_drop_cnt",  {24'd0, drop_cnt},  32'd0);
    cyc(2);
    clr = 1'b0;
    cyc();

    // streaming at full rate
    out_ready = 1'b1;
    send(32'h11);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data",  out_data,           32'h11);
    chk("str_occ_a", {30'd0, occupancy}, 32'd1);
    send(32'h22);
    chk("str_occ_b", {30'd0, occupancy}, 32'd1);
    send(32'h33);
    chk("str_occ_c", {30'd0, occupancy}, 32'd1);
    chk("str_data_c", out_data, 32'h33);
    idle(1);
    chk("str_drain_occ", {30'd0, occupancy}, 32'd0);

    // skid fill and stall
    fill2(32'hA1, 32'hA2);
    chk("skid_occ",      {30'd0, occupancy}, 32'd2);
    chk("skid_in_ready", {31'd0, in_ready},  32'd0);
    chk("skid_head",     out_data,           32'hA1);
    idle(2);
    chk("skid_stable",   out_data,           32'hA1);
    out_ready = 1'b1;
    cyc();
    chk("skid_next",     out_data,           32'hA2);
    chk("skid_occ_1",    {30'd0, occupancy}, 32'd1);
    cyc();
    chk("skid_empty",    {30'd0, occupancy}, 32'd0);

    // build drop_cnt up to 5
    fill2(32'hB1, 32'hB2);
    do_flush();
    fill2(32'hB3, 32'hB4);
    do_flush();
    send(32'hB5);
    in_valid = 1'b0;
    do_flush();
    chk("drop_cnt_5", {24'd0, drop_cnt}, 32'd5);

    // flush with two held; payload offered during flush must vanish
    fill2(32'hC1, 32'hC2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    exp_q.delete();
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    #0;
    chk("fl_occ",       {30'd0, occupancy}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_drop_cnt",  {24'd0, drop_cnt},  32'd7);
    chk("fl_stale",     out_data,           32'hC1);
    out_ready = 1'b1;
    idle(2);
    chk("fl_still_idle", {31'd0, out_valid}, 32'd0);

    // accept and release together in ONE
    out_ready = 1'b0;
    send(32'h40);
    out_ready = 1'b1;
    send(32'h5A);
    chk("sim_occ",  {30'd0, occupancy}, 32'd1);
    chk("sim_data", out_data,           32'h5A);
    idle(1);
    chk("sim_empty", {30'd0, occupancy}, 32'd0);

    // drop counter saturation on the narrow instance
    sat_round(2'd2);
    sat_round(2'd3);
    sat_round(2'd3);

    // async clear mid-cycle with two entries held
    fill2(32'h71, 32'h72);
    chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
    #2;
    clr = 1'b1;
    exp_q.delete();
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_in_ready",  {31'd0, in_ready},  32'd1);
    chk("ar_out_data",  out_data,           32'd0);
    chk("ar_occ",       {30'd0, occupancy}, 32'd0);
    chk("ar_drop_cnt",  {24'd0, drop_cnt},  32'd0);
    chk("ar_sat_cnt",   {30'd0, s_drop_cnt}, 32'd0);
    #1;
    clr = 1'b0;
    out_ready = 1'b1;
    send(32'h99);
    chk("ar_first_acc", out_data, 32'h99);
    chk("ar_first_occ", {30'd0, occupancy}, 32'd1);
    idle(2);

    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
